// File: rtl/ctrl_pkg.sv
// Shared encodings for the multi-cycle ID-stage control unit: modes, opcodes,
// ALU commands, FSM states and ARM condition codes.
package ctrl_pkg;

  localparam logic [1:0] MODE_COMP = 2'b00;
  localparam logic [1:0] MODE_MEM  = 2'b01;
  localparam logic [1:0] MODE_BR   = 2'b10;
  localparam logic [1:0] MODE_ILL  = 2'b11;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_EOR = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_ADD = 4'b0100;
  localparam logic [3:0] OP_ADC = 4'b0101;
  localparam logic [3:0] OP_SBC = 4'b0110;
  localparam logic [3:0] OP_TST = 4'b1000;
  localparam logic [3:0] OP_CMP = 4'b1010;
  localparam logic [3:0] OP_ORR = 4'b1100;
  localparam logic [3:0] OP_MOV = 4'b1101;
  localparam logic [3:0] OP_MVN = 4'b1111;

  localparam logic [3:0] EXE_MOV = 4'b0001;
  localparam logic [3:0] EXE_ADD = 4'b0010;
  localparam logic [3:0] EXE_ADC = 4'b0011;
  localparam logic [3:0] EXE_SUB = 4'b0100;
  localparam logic [3:0] EXE_SBC = 4'b0101;
  localparam logic [3:0] EXE_AND = 4'b0110;
  localparam logic [3:0] EXE_ORR = 4'b0111;
  localparam logic [3:0] EXE_EOR = 4'b1000;
  localparam logic [3:0] EXE_MVN = 4'b1001;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;
  localparam logic [3:0] COND_NV = 4'b1111;

  typedef enum logic [1:0] {StIdle, StIssue, StMemWait} state_e;

  // sr is {N,Z,C,V}; NV is treated as never-execute.
  function automatic logic cond_pass(logic [3:0] cond, logic [3:0] sr);
    logic n, z, c, v;
    {n, z, c, v} = sr;
    case (cond)
      COND_EQ: return z;
      COND_NE: return ~z;
      COND_CS: return c;
      COND_CC: return ~c;
      COND_MI: return n;
      COND_PL: return ~n;
      COND_VS: return v;
      COND_VC: return ~v;
      COND_HI: return c & ~z;
      COND_LS: return ~c | z;
      COND_GE: return n == v;
      COND_LT: return n != v;
      COND_GT: return ~z & (n == v);
      COND_LE: return z | (n != v);
      COND_AL: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Pure combinational decode of mode/op_code/S into the EXE/MEM/WB control bundle.
module ctrl_decode
  import ctrl_pkg::*;
#(
  parameter int unsigned OPC_W = 4,
  parameter int unsigned CMD_W = 4
) (
  input  logic [1:0]       mode,
  input  logic [OPC_W-1:0] op_code,
  input  logic             S,
  output logic [CMD_W-1:0] exe_cmd,
  output logic             mem_read,
  output logic             mem_write,
  output logic             wb_en,
  output logic             branch,
  output logic             update_sr,
  output logic             illegal,
  output logic             is_mem
);

  always_comb begin
    exe_cmd   = '0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    wb_en     = 1'b0;
    branch    = 1'b0;
    update_sr = 1'b0;
    illegal   = 1'b0;
    is_mem    = 1'b0;
    unique case (mode)
      MODE_COMP: begin
        wb_en     = 1'b1;
        update_sr = S;
        case (op_code)
          OPC_W'(OP_AND): exe_cmd = CMD_W'(EXE_AND);
          OPC_W'(OP_EOR): exe_cmd = CMD_W'(EXE_EOR);
          OPC_W'(OP_SUB): exe_cmd = CMD_W'(EXE_SUB);
          OPC_W'(OP_ADD): exe_cmd = CMD_W'(EXE_ADD);
          OPC_W'(OP_ADC): exe_cmd = CMD_W'(EXE_ADC);
          OPC_W'(OP_SBC): exe_cmd = CMD_W'(EXE_SBC);
          OPC_W'(OP_ORR): exe_cmd = CMD_W'(EXE_ORR);
          OPC_W'(OP_MOV): exe_cmd = CMD_W'(EXE_MOV);
          OPC_W'(OP_MVN): exe_cmd = CMD_W'(EXE_MVN);
          OPC_W'(OP_TST): begin
            exe_cmd   = CMD_W'(EXE_AND);
            wb_en     = 1'b0;
            update_sr = 1'b1;
          end
          OPC_W'(OP_CMP): begin
            exe_cmd   = CMD_W'(EXE_SUB);
            wb_en     = 1'b0;
            update_sr = 1'b1;
          end
          default: begin
            wb_en     = 1'b0;
            update_sr = 1'b0;
            illegal   = 1'b1;
          end
        endcase
      end
      MODE_MEM: begin
        exe_cmd   = CMD_W'(EXE_ADD);
        mem_read  = S;
        wb_en     = S;
        mem_write = ~S;
        is_mem    = 1'b1;
      end
      MODE_BR:  branch  = 1'b1;
      MODE_ILL: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/ctrl_unit_mc.sv
// Registered, handshaked ID-stage control unit with memory-op timeout tracking.
// Define CTRL_UNIT_COND_EN to enable ARM condition evaluation at accept.
module ctrl_unit_mc
  import ctrl_pkg::*;
#(
  parameter int unsigned OPC_W       = 4,
  parameter int unsigned CMD_W       = 4,
  parameter int unsigned TIMEOUT_CYC = 16,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       mode,
  input  logic [OPC_W-1:0] op_code,
  input  logic             S,
  input  logic [3:0]       cond,
  input  logic [3:0]       sr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CMD_W-1:0] exe_cmd,
  output logic             mem_read,
  output logic             mem_write,
  output logic             wb_en,
  output logic             branch,
  output logic             update_sr,
  output logic             illegal,
  input  logic             mem_done,
  output logic             mem_busy,
  output logic             mem_err,
  output logic [CNT_W-1:0] instr_cnt
);

  localparam int unsigned TO_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

  state_e state_q, state_d;

  logic [CMD_W-1:0] dec_exe_cmd;
  logic dec_mem_read, dec_mem_write, dec_wb_en, dec_branch, dec_update_sr;
  logic dec_illegal, dec_is_mem;

  logic [CMD_W-1:0] exe_cmd_q;
  logic mem_read_q, mem_write_q, wb_en_q, branch_q, update_sr_q, illegal_q, is_mem_q;
  logic [TO_W-1:0]  to_cnt_q;
  logic [CNT_W-1:0] instr_cnt_q;

  logic exec, accept, to_hit;

  ctrl_decode #(
    .OPC_W(OPC_W),
    .CMD_W(CMD_W)
  ) u_decode (
    .mode     (mode),
    .op_code  (op_code),
    .S        (S),
    .exe_cmd  (dec_exe_cmd),
    .mem_read (dec_mem_read),
    .mem_write(dec_mem_write),
    .wb_en    (dec_wb_en),
    .branch   (dec_branch),
    .update_sr(dec_update_sr),
    .illegal  (dec_illegal),
    .is_mem   (dec_is_mem)
  );

`ifdef CTRL_UNIT_COND_EN
  assign exec = cond_pass(cond, sr);
`else
  logic unused_cond;
  assign unused_cond = ^{cond, sr};
  assign exec = 1'b1;
`endif

  assign accept = in_valid & in_ready & ~flush;
  assign to_hit = (to_cnt_q == TO_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: if (accept) state_d = StIssue;
      StIssue: begin
        if (flush)          state_d = StIdle;
        else if (out_ready) state_d = is_mem_q ? StMemWait : (accept ? StIssue : StIdle);
      end
      StMemWait: if (mem_done || to_hit) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    mem_busy  = 1'b0;
    mem_err   = 1'b0;
    case (state_q)
      StIdle: in_ready = 1'b1;
      StIssue: begin
        out_valid = 1'b1;
        in_ready  = out_ready & ~is_mem_q;
      end
      StMemWait: begin
        mem_busy = 1'b1;
        mem_err  = to_hit & ~mem_done;
      end
      default: ;
    endcase
  end

  // Bundle loads only on accept, so it holds while out_valid & ~out_ready.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      exe_cmd_q   <= '0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      wb_en_q     <= 1'b0;
      branch_q    <= 1'b0;
      update_sr_q <= 1'b0;
      illegal_q   <= 1'b0;
      is_mem_q    <= 1'b0;
      to_cnt_q    <= '0;
      instr_cnt_q <= '0;
    end else begin
      if (accept) begin
        exe_cmd_q   <= exec ? dec_exe_cmd : '0;
        mem_read_q  <= exec & dec_mem_read;
        mem_write_q <= exec & dec_mem_write;
        wb_en_q     <= exec & dec_wb_en;
        branch_q    <= exec & dec_branch;
        update_sr_q <= exec & dec_update_sr;
        illegal_q   <= dec_illegal;
        is_mem_q    <= exec & dec_is_mem;
        instr_cnt_q <= instr_cnt_q + CNT_W'(1);
      end else if (state_q == StIssue && (flush || out_ready)) begin
        exe_cmd_q   <= '0;
        mem_read_q  <= 1'b0;
        mem_write_q <= 1'b0;
        wb_en_q     <= 1'b0;
        branch_q    <= 1'b0;
        update_sr_q <= 1'b0;
        illegal_q   <= 1'b0;
        is_mem_q    <= 1'b0;
      end
      to_cnt_q <= (state_q == StMemWait) ? to_cnt_q + TO_W'(1) : '0;
    end
  end

  assign exe_cmd   = exe_cmd_q;
  assign mem_read  = mem_read_q;
  assign mem_write = mem_write_q;
  assign wb_en     = wb_en_q;
  assign branch    = branch_q;
  assign update_sr = update_sr_q;
  assign illegal   = illegal_q;
  assign instr_cnt = instr_cnt_q;

endmodule

// File: tb/tb_ctrl_unit_mc.sv
// Directed scoreboard bench for ctrl_unit_mc; expected bundles are queued at
// drive time and popped when the DUT presents its registered output.
module tb_ctrl_unit_mc;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready, S, out_valid, out_ready;
  logic [1:0]  mode;
  logic [3:0]  op_code, cond, sr, exe_cmd;
  logic        mem_read, mem_write, wb_en, branch, update_sr, illegal;
  logic        mem_done, mem_busy, mem_err;
  logic [15:0] instr_cnt;
  logic [9:0]  bundle;

  int n_cmp = 0;
  int n_bad = 0;
  int exp_cnt = 0;
  logic [9:0] exp_q[$];

  assign bundle = {exe_cmd, mem_read, mem_write, wb_en, branch, update_sr, illegal};

  always #5 clk = ~clk;

  ctrl_unit_mc #(
    .OPC_W(4),
    .CMD_W(4),
    .TIMEOUT_CYC(16),
    .CNT_W(16)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .mode     (mode),
    .op_code  (op_code),
    .S        (S),
    .cond     (cond),
    .sr       (sr),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .exe_cmd  (exe_cmd),
    .mem_read (mem_read),
    .mem_write(mem_write),
    .wb_en    (wb_en),
    .branch   (branch),
    .update_sr(update_sr),
    .illegal  (illegal),
    .mem_done (mem_done),
    .mem_busy (mem_busy),
    .mem_err  (mem_err),
    .instr_cnt(instr_cnt)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drives one instruction for a cycle; caller guarantees in_ready and no flush.
  task automatic send(input logic [1:0] m, input logic [3:0] op, input logic s,
                      input logic [9:0] exp);
    mode = m;
    op_code = op;
    S = s;
    in_valid = 1'b1;
    exp_q.push_back(exp);
    exp_cnt++;
    tick();
    in_valid = 1'b0;
  endtask

  // Empty scoreboard yields an impossible bundle (read and write both set).
  task automatic check_out(input string tag);
    logic [9:0] e;
    e = (exp_q.size() != 0) ? exp_q.pop_front() : 10'h3ff;
    chk(tag, {21'd0, out_valid, bundle}, {21'd0, 1'b1, e});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int pulses;
    int at;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; mode = 2'b00; op_code = 4'h0; S = 1'b0;
    cond = 4'b1110; sr = 4'b0000; out_ready = 1'b0; mem_done = 1'b0;
    tick();
    tick();
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_bundle", bundle, 0);
    chk("rst_mem", {mem_busy, mem_err}, 0);
    chk("rst_cnt", instr_cnt, 0);
    rst = 1'b0;
    tick();

    // ADD S=1, consumed immediately
    out_ready = 1'b1;
    send(2'b00, 4'b0100, 1'b1, {4'b0010, 6'b001010});
    check_out("add");
    chk("add_cnt", instr_cnt, exp_cnt);
    tick();
    chk("add_retire", out_valid, 0);

    // CMP S=0 held under backpressure
    out_ready = 1'b0;
    send(2'b00, 4'b1010, 1'b0, {4'b0100, 6'b000010});
    check_out("cmp");
    for (int i = 0; i < 3; i++) begin
      chk("cmp_hold_in_ready", in_ready, 0);
      chk("cmp_hold_bundle", {out_valid, bundle}, {1'b1, 4'b0100, 6'b000010});
      tick();
    end
    out_ready = 1'b1;
    #1;
    chk("cmp_release_in_ready", in_ready, 1);
    send(2'b00, 4'b1101, 1'b0, {4'b0001, 6'b001000});
    check_out("mov_b2b");
    chk("mov_cnt", instr_cnt, exp_cnt);
    tick();
    chk("mov_retire", out_valid, 0);

    // LDR with mem_done in the third MEM_WAIT cycle
    send(2'b01, 4'b0000, 1'b1, {4'b0010, 6'b101000});
    check_out("ldr");
    chk("ldr_in_ready", in_ready, 0);
    tick();
    chk("ldr_wait1", {mem_busy, in_ready, out_valid}, 3'b100);
    tick();
    chk("ldr_wait2", mem_busy, 1);
    tick();
    mem_done = 1'b1;
    #1;
    chk("ldr_wait3", {mem_busy, mem_err}, 2'b10);
    tick();
    mem_done = 1'b0;
    chk("ldr_idle", {mem_busy, in_ready}, 2'b01);

    // STR timeout: exactly one mem_err, in the 16th MEM_WAIT cycle
    send(2'b01, 4'b0000, 1'b0, {4'b0010, 6'b010000});
    check_out("str");
    tick();
    pulses = 0;
    at = 0;
    for (int c = 1; c <= 16; c++) begin
      if (mem_err) begin pulses++; at = c; end
      tick();
    end
    chk("str_to_pulses", pulses, 1);
    chk("str_to_cycle", at, 16);
    chk("str_to_idle", {mem_busy, mem_err}, 0);

    // STR with mem_done on the timeout cycle: no pulse
    send(2'b01, 4'b0000, 1'b0, {4'b0010, 6'b010000});
    check_out("str2");
    tick();
    pulses = 0;
    for (int c = 1; c <= 16; c++) begin
      mem_done = (c == 16);
      #1;
      if (mem_err) pulses++;
      tick();
    end
    mem_done = 1'b0;
    chk("str_done_pulses", pulses, 0);
    chk("str_done_idle", mem_busy, 0);
    chk("str_cnt", instr_cnt, exp_cnt);

    // flush during ISSUE drops the incoming instruction
    out_ready = 1'b0;
    send(2'b00, 4'b0100, 1'b0, {4'b0010, 6'b001000});
    check_out("add_pre_flush");
    out_ready = 1'b1;
    mode = 2'b00; op_code = 4'b0001; S = 1'b0;
    in_valid = 1'b1;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    chk("flush_issue_valid", out_valid, 0);
    chk("flush_issue_cnt", instr_cnt, exp_cnt);
    in_valid = 1'b1;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    chk("flush_idle_valid", out_valid, 0);
    chk("flush_idle_cnt", instr_cnt, exp_cnt);

    // back-to-back illegal, unlisted opcode, TST, ORR, branch, SBC
    send(2'b11, 4'b0100, 1'b1, {4'b0000, 6'b000001});
    check_out("mode11");
    send(2'b00, 4'b0011, 1'b1, {4'b0000, 6'b000001});
    check_out("op0011");
    send(2'b00, 4'b1000, 1'b0, {4'b0110, 6'b000010});
    check_out("tst");
    send(2'b00, 4'b1100, 1'b1, {4'b0111, 6'b001010});
    check_out("orr");
    send(2'b10, 4'b0000, 1'b1, {4'b0000, 6'b000100});
    check_out("branch");
    send(2'b00, 4'b0110, 1'b0, {4'b0101, 6'b001000});
    check_out("sbc");
    chk("b2b_cnt", instr_cnt, exp_cnt);
    tick();
    chk("b2b_retire", out_valid, 0);

`ifdef CTRL_UNIT_COND_EN
    cond = 4'b0000;
    sr = 4'b0000;
    send(2'b00, 4'b1101, 1'b0, {4'b0000, 6'b000000});
    check_out("cond_eq_fail");
    tick();
    sr = 4'b0100;
    send(2'b00, 4'b1101, 1'b0, {4'b0001, 6'b001000});
    check_out("cond_eq_pass");
    tick();
    sr = 4'b0000;
    send(2'b01, 4'b0000, 1'b1, {4'b0000, 6'b000000});
    check_out("cond_ldr_fail");
    tick();
    chk("cond_ldr_no_wait", {mem_busy, out_valid}, 0);
    chk("cond_cnt", instr_cnt, exp_cnt);
    cond = 4'b1110;
`endif

    // asynchronous reset in the middle of MEM_WAIT
    send(2'b01, 4'b0000, 1'b1, {4'b0010, 6'b101000});
    check_out("ldr_pre_rst");
    tick();
    chk("pre_rst_busy", mem_busy, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_state", {mem_busy, in_ready, out_valid}, 3'b010);
    chk("mid_rst_cnt", instr_cnt, 0);
    exp_cnt = 0;
    tick();
    rst = 1'b0;
    tick();
    chk("post_rst_idle", {mem_busy, mem_err, in_ready}, 3'b001);
    chk("sb_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ctrl_unit_mc.md
Name: ctrl_unit_mc

Overview:
- Next-generation ID-stage control unit: registered, handshaked, multi-cycle successor to the combinational decoder.
- Decodes mode/opcode/S into EXE/MEM/WB control, holds the ID/EXE interface with valid/ready, and tracks outstanding memory ops with a timeout counter.
- Sits between instruction decode and the ID/EXE pipeline register; the hazard unit drives stall via out_ready, and the branch unit drives flush.

Parameters:
- OPC_W, 4, opcode field width.
- CMD_W, 4, execute-command width.
- TIMEOUT_CYC, 16, max MEM_WAIT cycles before mem_err (≥2).
- CNT_W, 16, width of retired-instruction counter.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous kill of the held/accepted instruction.
- in_valid  in  1  decoded instruction fields valid.
- in_ready  out  1  unit can accept this cycle.
- mode  in  2  00 compute, 01 memory, 10 branch, 11 illegal.
- op_code  in  OPC_W  data-processing opcode.
- S  in  1  set-flags bit; for memory mode, 1 = load, 0 = store.
- cond  in  4  ARM condition field.
- sr  in  4  status flags {N,Z,C,V}.
- out_valid  out  1  control bundle valid.
- out_ready  in  1  ID/EXE register accepts.
- exe_cmd  out  CMD_W  ALU command.
- mem_read, mem_write, wb_en, branch, update_sr  out  1 each  control bits.
- illegal  out  1  bundle is an illegal instruction (all effect bits 0).
- mem_done  in  1  memory stage completed outstanding op.
- mem_busy  out  1  high in MEM_WAIT.
- mem_err  out  1  one-cycle pulse on timeout.
- instr_cnt  out  CNT_W  accepted-instruction count, wraps.

Behaviour:
- Reset (async, rst=1): state=IDLE; all outputs 0, except in_ready, which follows its IDLE equation (1).
- Opcode map (compute): AND 0000→0110; EOR 0001→1000; SUB 0010→0100; ADD 0100→0010; ADC 0101→0011; SBC 0110→0101; TST 1000→0110; CMP 1010→0100; ORR 1100→0111; MOV 1101→0001; MVN 1111→1001.
  - wb_en=1 for all except TST and CMP.
  - update_sr=S for compute ops; update_sr=1 for TST/CMP regardless of S.
- Memory mode: exe_cmd=0010; mem_read=S; wb_en=S; mem_write=~S; update_sr=0.
- Branch mode: branch=1; all other bits 0.
- Illegal (mode 11 or an unlisted compute opcode): illegal=1, all other bits 0, still issued with out_valid=1.
- Latency: 1 cycle from accept to out_valid. Outputs are registered and stay stable while out_valid & ~out_ready.
- FSM states:
  - IDLE: in_ready=1, out_valid=0. Accept (in_valid & ~flush) → ISSUE.
  - ISSUE: out_valid=1; in_ready = out_ready & ~held_is_mem.
    - On out_ready with held memory op → MEM_WAIT (out_valid=0).
    - On out_ready with held non-memory op: if new accept, stay ISSUE; else → IDLE.
  - MEM_WAIT: mem_busy=1, in_ready=0; counter increments each cycle.
    - mem_done → IDLE.
    - Counter reaching TIMEOUT_CYC-1 without mem_done → pulse mem_err, → IDLE.
    - mem_done on the same cycle as the timeout: done wins, no mem_err.
- flush: in IDLE or ISSUE, forces IDLE and out_valid=0 next cycle; the incoming instruction is dropped and not counted. Ignored in MEM_WAIT, because the memory op is already committed.
- instr_cnt increments on each accept, wraps at 2^CNT_W. A flushed-cycle input is not counted.
- Reset mid-MEM_WAIT: immediate return to IDLE, counter cleared.

Optional Feature:
- Macro CTRL_UNIT_COND_EN.
- Defined: at accept, cond is evaluated against sr (EQ…LE; AL=1110; 1111 treated as never). A failing instruction still issues with out_valid=1, but all effect bits (wb_en, mem_*, branch, update_sr) are 0 and exe_cmd=0. It never enters MEM_WAIT and is still counted.
- Undefined: cond and sr are ignored; every instruction executes.

Decomposition:
- Package ctrl_pkg: mode encodings, opcode localparams, exe_cmd localparams, FSM state enum, condition-code constants.
- Sub-module ctrl_decode: pure combinational decode (mode, op_code, S → control bundle + illegal).
- ctrl_unit_mc holds the FSM, registers, and counters.

Test Plan:
- ADD with S=1, out_ready=1 → next cycle out_valid=1, exe_cmd=0010, wb_en=1, update_sr=1; instr_cnt=1.
- CMP with S=0, out_ready=0 for 3 cycles → exe_cmd=0100, wb_en=0, update_sr=1, bundle held stable; in_ready=0 throughout.
- LDR (mode 01, S=1) → mem_read=1, wb_en=1; then mem_busy=1 and in_ready=0 until mem_done in cycle 3 → IDLE.
- STR with no mem_done, TIMEOUT_CYC=16 → single mem_err pulse at the 16th MEM_WAIT cycle; mem_done asserted on the same cycle instead → no pulse.
- flush during ISSUE with in_valid=1 → out_valid=0 next cycle, instr_cnt unchanged; mode 11 → illegal=1, all control bits 0.
- With CTRL_UNIT_COND_EN: cond=EQ, sr Z=0, MOV → out_valid=1, wb_en=0; sr Z=1 → wb_en=1, exe_cmd=0001.
